// File: rtl/hdmi_tmds_enc.sv
// HDMI TMDS lane encoder: 8b/10b video, control, TERC4 and guard-band symbols.
// Two register stages (inputs, then symbol + running disparity), 2-clock latency.
module hdmi_tmds_enc #(
   parameter int CHANNEL = 0,
   parameter int DISP_W  = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [2:0]        mode_i,
   input  logic [7:0]        data_i,
   input  logic [1:0]        ctrl_i,
   input  logic [3:0]        aux_i,
   output logic [9:0]        tmds_o,
   output logic [DISP_W-1:0] disp_o
);

   localparam logic [2:0] MODE_CTRL  = 3'd0;
   localparam logic [2:0] MODE_VIDEO = 3'd1;
   localparam logic [2:0] MODE_TERC4 = 3'd2;
   localparam logic [2:0] MODE_VGB   = 3'd3;
   localparam logic [2:0] MODE_DGB   = 3'd4;

   localparam logic [9:0] GB_A = 10'b1011001100;
   localparam logic [9:0] GB_B = 10'b0100110011;

   function automatic logic [9:0] terc4(input logic [3:0] a);
      logic [9:0] s;
      case (a)
         4'd0:    s = 10'b1010011100;
         4'd1:    s = 10'b1001100011;
         4'd2:    s = 10'b1011100100;
         4'd3:    s = 10'b1011100010;
         4'd4:    s = 10'b0101110001;
         4'd5:    s = 10'b0100011110;
         4'd6:    s = 10'b0110001110;
         4'd7:    s = 10'b0100111100;
         4'd8:    s = 10'b1011001100;
         4'd9:    s = 10'b0100111001;
         4'd10:   s = 10'b0110011100;
         4'd11:   s = 10'b1011000111;
         4'd12:   s = 10'b1010001110;
         4'd13:   s = 10'b1001110001;
         4'd14:   s = 10'b0101100011;
         default: s = 10'b1011000011;
      endcase
      return s;
   endfunction

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'b00:   s = 10'b1101010100;
         2'b01:   s = 10'b0010101011;
         2'b10:   s = 10'b0101010100;
         default: s = 10'b1010101011;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
      return n;
   endfunction

   // Transition-minimising stage: XOR or XNOR chain, bit 8 records which.
   function automatic logic [8:0] qm_encode(input logic [7:0] d);
      logic [8:0] q;
      logic [3:0] n1;
      logic       flip;
      n1   = popcount8(d);
      flip = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ flip;
      q[8] = ~flip;
      return q;
   endfunction

   logic [2:0]               mode_q;
   logic [7:0]               data_q;
   logic [1:0]               ctrl_q;
   logic [3:0]               aux_q;
   logic                     vld_q;
   logic [9:0]               tmds_q, tmds_d;
   logic signed [DISP_W-1:0] disp_q, disp_d;

   logic [8:0]        q_m;
   logic [3:0]        n1q;
   logic [DISP_W-1:0] n1q_w;
   logic [DISP_W-1:0] bal;
   logic [DISP_W-1:0] two;

   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q <= '0;
         data_q <= '0;
         ctrl_q <= '0;
         aux_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         mode_q <= mode_i;
         data_q <= data_i;
         ctrl_q <= ctrl_i;
         aux_q  <= aux_i;
         vld_q  <= 1'b1;
      end
   end

   always_comb begin
      q_m    = qm_encode(data_q);
      n1q    = popcount8(q_m[7:0]);
      n1q_w  = {{(DISP_W-4){1'b0}}, n1q};
      // bal is N1q - N0q = 2*N1q - 8
      bal    = n1q_w + n1q_w - DISP_W'(8);
      two    = DISP_W'(2);
      tmds_d = '0;
      disp_d = '0;
      // Stage 1 holds no real input for one cycle after reset: emit zeros.
      if (vld_q) begin
         case (mode_q)
            MODE_VIDEO: begin
               if ((disp_q == '0) || (n1q == 4'd4)) begin
                  tmds_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
                  disp_d = q_m[8] ? (disp_q + bal) : (disp_q - bal);
               end else if ((!disp_q[DISP_W-1] && (n1q > 4'd4)) ||
                            (disp_q[DISP_W-1] && (n1q < 4'd4))) begin
                  tmds_d = {1'b1, q_m[8], ~q_m[7:0]};
                  disp_d = disp_q + (q_m[8] ? two : '0) - bal;
               end else begin
                  tmds_d = {1'b0, q_m[8], q_m[7:0]};
                  disp_d = disp_q - (q_m[8] ? '0 : two) + bal;
               end
            end
            MODE_TERC4: tmds_d = terc4(aux_q);
            MODE_VGB:   tmds_d = (CHANNEL == 1) ? GB_B : GB_A;
            MODE_DGB:   tmds_d = (CHANNEL == 0) ? terc4({2'b11, ctrl_q}) : GB_B;
            MODE_CTRL:  tmds_d = ctrl_code(ctrl_q);
            default:    tmds_d = ctrl_code(ctrl_q);
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tmds_q <= '0;
         disp_q <= '0;
      end else begin
         tmds_q <= tmds_d;
         disp_q <= disp_d;
      end
   end

   assign tmds_o = tmds_q;
   assign disp_o = disp_q;

endmodule

// File: tb/tb_hdmi_tmds_enc.sv
// Bench for hdmi_tmds_enc: one instance per lane, fixed vectors then random
// traffic against a behavioural model of the TMDS rules.
module tb_hdmi_tmds_enc;

   localparam int DW = 6;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    mode  = '0;
   logic [7:0]    data  = '0;
   logic [1:0]    ctrl  = '0;
   logic [3:0]    aux   = '0;
   logic [9:0]    tmds0, tmds1, tmds2;
   logic [DW-1:0] disp0, disp1, disp2;

   always #5 clock = ~clock;

   hdmi_tmds_enc #(.CHANNEL(0), .DISP_W(DW)) u_ch0 (
      .clock(clock), .reset(reset), .mode_i(mode), .data_i(data),
      .ctrl_i(ctrl), .aux_i(aux), .tmds_o(tmds0), .disp_o(disp0));
   hdmi_tmds_enc #(.CHANNEL(1), .DISP_W(DW)) u_ch1 (
      .clock(clock), .reset(reset), .mode_i(mode), .data_i(data),
      .ctrl_i(ctrl), .aux_i(aux), .tmds_o(tmds1), .disp_o(disp1));
   hdmi_tmds_enc #(.CHANNEL(2), .DISP_W(DW)) u_ch2 (
      .clock(clock), .reset(reset), .mode_i(mode), .data_i(data),
      .ctrl_i(ctrl), .aux_i(aux), .tmds_o(tmds2), .disp_o(disp2));

   int checks = 0;
   int errors = 0;
   int m_cnt  = 0;

   logic [9:0] terc_tab [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

   // {tmds ch0, tmds ch1, tmds ch2, disp as 8-bit two's complement}
   logic [37:0] exp_q[$];

   typedef struct {
      logic [2:0] mode;
      logic [7:0] data;
      logic [1:0] ctrl;
      logic [3:0] aux;
      logic [9:0] t0;
      logic [9:0] t1;
      logic [9:0] t2;
      int         d;
   } vec_t;

   vec_t vt[12];

   function automatic logic [37:0] pack(input logic [9:0] t0, input logic [9:0] t1,
                                        input logic [9:0] t2, input int d);
      return {t0, t1, t2, 8'(d)};
   endfunction

   function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   // Reference encoder: integer arithmetic on ones counts, running total in m_cnt.
   function automatic logic [37:0] model(input logic [2:0] md, input logic [7:0] d,
                                         input logic [1:0] c, input logic [3:0] a);
      int         n1, n1q, n0q;
      bit         flip, q8;
      bit [7:0]   q;
      logic [9:0] s;
      if (md == 3'd1) begin
         n1   = $countones(d);
         flip = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
         q[0] = d[0];
         for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ flip;
         q8  = !flip;
         n1q = $countones(q);
         n0q = 8 - n1q;
         if (m_cnt == 0 || n1q == n0q) begin
            s = {!q8, q8, q8 ? q : ~q};
            m_cnt += q8 ? (n1q - n0q) : (n0q - n1q);
         end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
            s = {1'b1, q8, ~q};
            m_cnt += 2 * int'(q8) + (n0q - n1q);
         end else begin
            s = {1'b0, q8, q};
            m_cnt += -2 * int'(!q8) + (n1q - n0q);
         end
         return pack(s, s, s, m_cnt);
      end
      m_cnt = 0;
      case (md)
         3'd2:    return pack(terc_tab[a], terc_tab[a], terc_tab[a], 0);
         3'd3:    return pack(10'b1011001100, 10'b0100110011, 10'b1011001100, 0);
         3'd4:    return pack(terc_tab[{2'b11, c}], 10'b0100110011, 10'b0100110011, 0);
         default: return pack(ctrl_sym(c), ctrl_sym(c), ctrl_sym(c), 0);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic compare_out(input logic [37:0] e);
      int dv;
      check("tmds_ch0", int'(tmds0), int'(e[37:28]));
      check("tmds_ch1", int'(tmds1), int'(e[27:18]));
      check("tmds_ch2", int'(tmds2), int'(e[17:8]));
      dv = $signed(disp0);
      check("disp_ch0", dv, int'($signed(e[7:0])));
      check("disp_ch1", int'($signed(disp1)), int'($signed(e[7:0])));
      check("disp_ch2", int'($signed(disp2)), int'($signed(e[7:0])));
      checks++;
      if (dv > 10 || dv < -10) begin
         errors++;
         $display("FAIL disp_range actual %0d required -10..10", dv);
      end
   endtask

   // Drive one input symbol; compare the symbol driven on the previous cycle.
   task automatic step(input logic [2:0] md, input logic [7:0] d, input logic [1:0] c,
                       input logic [3:0] a, input logic [37:0] e);
      mode = md;
      data = d;
      ctrl = c;
      aux  = a;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      if (exp_q.size() >= 2) compare_out(exp_q.pop_front());
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) begin
         @(posedge clock);
         #1;
         compare_out('0);
      end
      reset = 1'b0;
      exp_q.delete();
      exp_q.push_back('0);   // first post-reset cycle still shows zeros
      m_cnt = 0;
   endtask

   task automatic rstep(input logic [2:0] md, input logic [7:0] d, input logic [1:0] c,
                        input logic [3:0] a);
      logic [37:0] e;
      e = model(md, d, c, a);
      step(md, d, c, a, e);
   endtask

   initial begin
      int r;
      logic [2:0] md;

      vt[0]  = '{3'd0, 8'h00, 2'b00, 4'd0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 0};
      vt[1]  = '{3'd0, 8'h00, 2'b01, 4'd0, 10'b0010101011, 10'b0010101011, 10'b0010101011, 0};
      vt[2]  = '{3'd0, 8'h00, 2'b10, 4'd0, 10'b0101010100, 10'b0101010100, 10'b0101010100, 0};
      vt[3]  = '{3'd0, 8'h00, 2'b11, 4'd0, 10'b1010101011, 10'b1010101011, 10'b1010101011, 0};
      vt[4]  = '{3'd1, 8'h00, 2'b00, 4'd0, 10'b0100000000, 10'b0100000000, 10'b0100000000, -8};
      vt[5]  = '{3'd1, 8'h00, 2'b00, 4'd0, 10'b1111111111, 10'b1111111111, 10'b1111111111, 2};
      vt[6]  = '{3'd3, 8'h00, 2'b00, 4'd0, 10'b1011001100, 10'b0100110011, 10'b1011001100, 0};
      vt[7]  = '{3'd4, 8'h00, 2'b10, 4'd0, 10'b0101100011, 10'b0100110011, 10'b0100110011, 0};
      vt[8]  = '{3'd4, 8'h00, 2'b00, 4'd0, 10'b1010001110, 10'b0100110011, 10'b0100110011, 0};
      vt[9]  = '{3'd5, 8'h00, 2'b01, 4'd0, 10'b0010101011, 10'b0010101011, 10'b0010101011, 0};
      vt[10] = '{3'd1, 8'h00, 2'b00, 4'd0, 10'b0100000000, 10'b0100000000, 10'b0100000000, -8};
      vt[11] = '{3'd7, 8'h00, 2'b10, 4'd0, 10'b0101010100, 10'b0101010100, 10'b0101010100, 0};

      do_reset(3);

      for (int i = 0; i < 12; i++)
         step(vt[i].mode, vt[i].data, vt[i].ctrl, vt[i].aux,
              pack(vt[i].t0, vt[i].t1, vt[i].t2, vt[i].d));

      for (int a = 0; a < 16; a++)
         step(3'd2, 8'h00, 2'b00, 4'(a), pack(terc_tab[a], terc_tab[a], terc_tab[a], 0));
      m_cnt = 0;

      // Video run, then a control burst, then video again from zero disparity.
      rstep(3'd1, 8'hA5, 2'b00, 4'd0);
      rstep(3'd1, 8'hFF, 2'b00, 4'd0);
      rstep(3'd1, 8'h0F, 2'b00, 4'd0);
      rstep(3'd0, 8'h00, 2'b11, 4'd0);
      rstep(3'd0, 8'h00, 2'b10, 4'd0);
      rstep(3'd1, 8'h00, 2'b00, 4'd0);

      for (int i = 0; i < 20000; i++) begin
         if (i == 10000) do_reset(1);
         r = $urandom_range(0, 99);
         if (r < 3) begin
            repeat ($urandom_range(1, 4))
               rstep(3'd0, 8'($urandom), 2'($urandom), 4'($urandom));
         end else if (r < 88) begin
            rstep(3'd1, 8'($urandom), 2'($urandom), 4'($urandom));
         end else begin
            md = 3'($urandom_range(2, 7));
            rstep(md, 8'($urandom), 2'($urandom), 4'($urandom));
         end
      end

      rstep(3'd0, 8'h00, 2'b00, 4'd0);
      rstep(3'd0, 8'h00, 2'b00, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
